// File: rtl/inst_rom_loader.sv
// Instruction ROM for the CPU fetch port, filled from a big-endian byte stream.
// Holds the core in reset while an image loads and releases it on the last byte.
module inst_rom_loader #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [31:0]   addr,
  output logic [31:0]   inst,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          reload,
  output logic          cpu_rst_o,
  output logic          ovf_o,
  output logic [AW:0]   words_o
);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_r;
  logic        ld_ready_r;
  logic        cpu_rst_r;
  logic        ovf_r;
  logic [AW:0] wr_ptr_r;
  logic [1:0]  byte_cnt_r;
  logic [23:0] stage_r;
  logic [31:0] mem [2**AW];

  logic          hs_s;
  logic          full_s;
  logic          wr_en_s;
  logic [31:0]   word_s;
  logic [23:0]   stage_nxt_s;
  logic [AW-1:0] rd_idx_s;
  logic          in_range_s;
  logic          hit_s;

  assign ld_ready  = ld_ready_r;
  assign cpu_rst_o = cpu_rst_r;
  assign ovf_o     = ovf_r;
  assign words_o   = wr_ptr_r;

  // Handshake qualification and word assembly; reload always beats a byte.
  always_comb begin
    hs_s        = ld_valid & ld_ready_r & ~reload;
    full_s      = wr_ptr_r[AW];
    word_s      = 32'h0000_0000;
    stage_nxt_s = stage_r;
    case (byte_cnt_r)
      2'd0: begin
        word_s             = {ld_byte, 24'h00_0000};
        stage_nxt_s[23:16] = ld_byte;
      end
      2'd1: begin
        word_s            = {stage_r[23:16], ld_byte, 16'h0000};
        stage_nxt_s[15:8] = ld_byte;
      end
      2'd2: begin
        word_s           = {stage_r[23:8], ld_byte, 8'h00};
        stage_nxt_s[7:0] = ld_byte;
      end
      2'd3: begin
        word_s = {stage_r, ld_byte};
      end
      default: begin
        word_s = 32'h0000_0000;
      end
    endcase
    if (hs_s && !full_s && !rst && (ld_last || (byte_cnt_r == 2'd3))) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Load/run control, write pointer, byte counter and overflow flag.
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      state_r    <= ST_LOAD;
      ld_ready_r <= 1'b1;
      cpu_rst_r  <= 1'b1;
      ovf_r      <= 1'b0;
      wr_ptr_r   <= {(AW+1){1'b0}};
      byte_cnt_r <= 2'd0;
      stage_r    <= 24'h00_0000;
    end else if (hs_s) begin
      if (full_s) begin
        ovf_r <= 1'b1;
      end else if (wr_en_s) begin
        wr_ptr_r   <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
        byte_cnt_r <= 2'd0;
        stage_r    <= 24'h00_0000;
      end else begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        stage_r    <= stage_nxt_s;
      end
      if (ld_last) begin
        state_r    <= ST_RUN;
        ld_ready_r <= 1'b0;
        cpu_rst_r  <= 1'b0;
      end
    end
  end

  // Memory array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_r[AW-1:0]] <= word_s;
    end
  end

  // Combinational fetch, gated so unwritten or out-of-range words read as NOP.
  always_comb begin
    rd_idx_s   = addr[AW+1:2];
    in_range_s = (addr[31:AW+2] == {(30-AW){1'b0}});
    hit_s      = ce && (state_r == ST_RUN) && in_range_s && ({1'b0, rd_idx_s} < wr_ptr_r);
    if (hit_s) begin
      inst = mem[rd_idx_s];
    end else begin
      inst = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: stimulus queues expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_inst_rom_loader;

  localparam int K_INST = 0, K_WORDS = 1, K_CRST = 2, K_RDY = 3, K_OVF = 4;
  localparam int K_INST2 = 5, K_WORDS2 = 6, K_CRST2 = 7, K_RDY2 = 8, K_OVF2 = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] inst, inst2;
  logic        ld_valid = 1'b0, ld_last = 1'b0, reload = 1'b0;
  logic [7:0]  ld_byte = 8'h00;
  logic        ld_ready, cpu_rst, ovf;
  logic [10:0] words;
  logic        b_valid = 1'b0, b_last = 1'b0, b_reload = 1'b0;
  logic [7:0]  b_byte = 8'h00;
  logic        ld_ready2, cpu_rst2, ovf2;
  logic [2:0]  words2;

  int          kq[$];
  logic [31:0] vq[$];
  string       nq[$];
  int          tests = 0;
  int          fails = 0;
  int          mk;
  logic [31:0] mv, act;
  string       mn;
  logic        done = 1'b0;

  always #5 clk = ~clk;

  inst_rom_loader #(.AW(10)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload(reload), .cpu_rst_o(cpu_rst), .ovf_o(ovf), .words_o(words)
  );

  inst_rom_loader #(.AW(2)) dut2 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst2),
    .ld_valid(b_valid), .ld_byte(b_byte), .ld_last(b_last), .ld_ready(ld_ready2),
    .reload(b_reload), .cpu_rst_o(cpu_rst2), .ovf_o(ovf2), .words_o(words2)
  );

  // Monitor: drain every queued expectation against the settled outputs.
  always @(negedge clk) begin
    while (kq.size() > 0) begin
      mk = kq.pop_front();
      mv = vq.pop_front();
      mn = nq.pop_front();
      case (mk)
        K_INST:   act = inst;
        K_WORDS:  act = 32'(words);
        K_CRST:   act = 32'(cpu_rst);
        K_RDY:    act = 32'(ld_ready);
        K_OVF:    act = 32'(ovf);
        K_INST2:  act = inst2;
        K_WORDS2: act = 32'(words2);
        K_CRST2:  act = 32'(cpu_rst2);
        K_RDY2:   act = 32'(ld_ready2);
        K_OVF2:   act = 32'(ovf2);
        default:  act = 32'hxxxx_xxxx;
      endcase
      tests = tests + 1;
      if (act !== mv) begin
        fails = fails + 1;
        $display("FAIL %s: got %h expected %h", mn, act, mv);
      end
    end
  end

  // Watchdog: fail the run if the stimulus never completes.
  initial begin
    #1000000;
    if (!done) begin
      fails = fails + 1;
      $display("FAIL watchdog: timeout waiting for test completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input logic [31:0] v, input string nm);
    kq.push_back(kind);
    vq.push_back(v);
    nq.push_back(nm);
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_byte = 8'h00; ld_last = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b, input logic last);
    b_valid = 1'b1; b_byte = b; b_last = last;
    tick();
    b_valid = 1'b0; b_byte = 8'h00; b_last = 1'b0;
  endtask

  task automatic fetch(input int kind, input logic c, input logic [31:0] a,
                       input logic [31:0] e, input string nm);
    ce = c; addr = a;
    expect_v(kind, e, nm);
    tick();
  endtask

  task automatic pulse_reload;
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  logic [7:0] bp_bytes [4];
  logic [7:0] img [8];
  int         gap;

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    ce = 1'b1; addr = 32'h0;
    #1;
    tests = tests + 1;
    if (ld_ready !== 1'b1 || cpu_rst !== 1'b1 || ovf !== 1'b0 ||
        words !== 11'd0 || inst !== 32'h0) begin
      fails = fails + 1;
      $display("FAIL reset_state: ready=%b cpu_rst=%b ovf=%b words=%0d inst=%h",
               ld_ready, cpu_rst, ovf, words, inst);
    end
    expect_v(K_RDY, 32'd1, "rst_ready");
    expect_v(K_CRST, 32'd1, "rst_cpu_rst");
    expect_v(K_OVF, 32'd0, "rst_ovf");
    expect_v(K_WORDS, 32'd0, "rst_words");
    expect_v(K_INST, 32'h0, "rst_inst");
    tick();

    // Basic load and run
    img[0] = 8'h3C; img[1] = 8'h01; img[2] = 8'h12; img[3] = 8'h34;
    img[4] = 8'h34; img[5] = 8'h21; img[6] = 8'h56; img[7] = 8'h78;
    for (int i = 0; i < 7; i++) send(img[i], 1'b0);
    expect_v(K_CRST, 32'd1, "basic_crst_before_last");
    expect_v(K_WORDS, 32'd1, "basic_words_7");
    send(img[7], 1'b1);
    expect_v(K_WORDS, 32'd2, "basic_words");
    expect_v(K_CRST, 32'd0, "basic_crst_release");
    expect_v(K_RDY, 32'd0, "basic_ready_low");
    fetch(K_INST, 1'b1, 32'h0, 32'h3C01_1234, "basic_addr0");
    fetch(K_INST, 1'b1, 32'h4, 32'h3421_5678, "basic_addr4");
    fetch(K_INST, 1'b1, 32'h7, 32'h3421_5678, "basic_addr7_lowbits");
    fetch(K_INST, 1'b1, 32'h8, 32'h0, "basic_addr8");
    fetch(K_INST, 1'b1, 32'h0000_1000, 32'h0, "basic_addr_high");

    // Reload in RUN together with a valid byte
    reload = 1'b1; ld_valid = 1'b1; ld_byte = 8'hFF;
    tick();
    reload = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00;
    expect_v(K_CRST, 32'd1, "reload_crst");
    expect_v(K_WORDS, 32'd0, "reload_words");
    expect_v(K_RDY, 32'd1, "reload_ready");
    fetch(K_INST, 1'b1, 32'h0, 32'h0, "reload_fetch0");
    fetch(K_INST, 1'b1, 32'h4, 32'h0, "reload_fetch4");

    // Reload in LOAD discards a partial word and beats the concurrent byte
    send(8'h99, 1'b0);
    send(8'h98, 1'b0);
    reload = 1'b1; ld_valid = 1'b1; ld_byte = 8'h77;
    tick();
    reload = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00;

    // Partial last word
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    send(8'hAA, 1'b1);
    expect_v(K_WORDS, 32'd2, "partial_words");
    expect_v(K_CRST, 32'd0, "partial_crst");
    fetch(K_INST, 1'b1, 32'h4, 32'hAA00_0000, "partial_addr4");
    fetch(K_INST, 1'b1, 32'h0, 32'h1122_3344, "partial_addr0");
    fetch(K_INST, 1'b0, 32'h0, 32'h0, "partial_ce0");
    fetch(K_INST, 1'b1, 32'h8, 32'h0, "partial_addr8");

    // Backpressure and gaps; ld_last on idle cycles must be ignored
    pulse_reload();
    bp_bytes[0] = 8'hDE; bp_bytes[1] = 8'hAD; bp_bytes[2] = 8'hBE; bp_bytes[3] = 8'hEF;
    for (int i = 0; i < 4; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        ld_valid = 1'b0; ld_byte = 8'h55; ld_last = 1'b1;
        expect_v(K_RDY, 32'd1, "bp_ready_gap");
        tick();
      end
      ld_last = 1'b0;
      expect_v(K_RDY, 32'd1, "bp_ready_hs");
      send(bp_bytes[i], i == 3);
    end
    expect_v(K_RDY, 32'd0, "bp_ready_after");
    expect_v(K_WORDS, 32'd1, "bp_words");
    fetch(K_INST, 1'b1, 32'h0, 32'hDEAD_BEEF, "bp_addr0");
    fetch(K_INST, 1'b1, 32'h4, 32'h0, "bp_addr4");

    // Reset mid-load
    pulse_reload();
    for (int i = 0; i < 6; i++) send(8'(8'h10 + i), 1'b0);
    expect_v(K_WORDS, 32'd1, "rstmid_words_before");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_v(K_WORDS, 32'd0, "rstmid_words");
    expect_v(K_CRST, 32'd1, "rstmid_crst");
    expect_v(K_RDY, 32'd1, "rstmid_ready");
    send(8'hA1, 1'b0); send(8'hB2, 1'b0); send(8'hC3, 1'b0); send(8'hD4, 1'b1);
    expect_v(K_CRST, 32'd0, "rstmid_crst_release");
    fetch(K_INST, 1'b1, 32'h0, 32'hA1B2_C3D4, "rstmid_addr0");

    // Overflow on the AW=2 instance
    for (int i = 1; i <= 20; i++) begin
      send2(8'(i), i == 20);
      if (i == 16) begin
        expect_v(K_OVF2, 32'd0, "ovf_not_yet");
        expect_v(K_WORDS2, 32'd4, "ovf_words_full");
      end
      if (i == 17) begin
        expect_v(K_OVF2, 32'd1, "ovf_set");
        expect_v(K_CRST2, 32'd1, "ovf_crst_held");
      end
    end
    expect_v(K_WORDS2, 32'd4, "ovf_words");
    expect_v(K_OVF2, 32'd1, "ovf_sticky");
    expect_v(K_CRST2, 32'd0, "ovf_run");
    expect_v(K_RDY2, 32'd0, "ovf_ready");
    fetch(K_INST2, 1'b1, 32'd12, 32'h0D0E_0F10, "ovf_addr12");
    fetch(K_INST2, 1'b1, 32'd0, 32'h0102_0304, "ovf_addr0");
    fetch(K_INST2, 1'b1, 32'd8, 32'h090A_0B0C, "ovf_addr8");
    fetch(K_INST2, 1'b1, 32'd16, 32'h0, "ovf_addr16");
    b_reload = 1'b1;
    tick();
    b_reload = 1'b0;
    expect_v(K_OVF2, 32'd0, "ovf_reload_clear");
    expect_v(K_WORDS2, 32'd0, "ovf_reload_words");
    expect_v(K_CRST2, 32'd1, "ovf_reload_crst");

    tick(); tick();
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    if (fails == 0) begin
      $display("PASS");
    end else begin
      $display("FAIL");
    end
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Instruction-memory responder for the CPU fetch port: it answers `ce`/`addr` fetches with 32-bit instruction words, and it is written from a byte-serial load stream. It holds the CPU core in reset through its own `cpu_rst_o` while a program image is loaded. Once the last byte is accepted, it releases the core. It sits beside the core top-level: it drives the core's `rom_data_i` and the core's `rst`, and it takes the core's `rom_ce_o` and `rom_addr_o`.

## Interface
- `AW`, default 10: word-address width. Memory depth is 2^AW words.
- `clk` input 1: single clock for the block and the core.
- `rst` input 1: synchronous, active-high reset.
- `ce` input 1: fetch enable, driven from the core's `rom_ce_o`.
- `addr` input 32: byte address of the fetch, driven from the core's `rom_addr_o`.
- `inst` output 32: fetched instruction word, driven to the core's `rom_data_i`.
- `ld_valid` input 1: the load byte is valid.
- `ld_byte` input 8: the load byte.
- `ld_last` input 1: marks the final byte of the image. Qualified by `ld_valid`.
- `ld_ready` output 1: the block accepts a byte this cycle.
- `reload` input 1: single-cycle request to discard the current image and start a new load.
- `cpu_rst_o` output 1: synchronous reset for the core. Active-high.
- `ovf_o` output 1: sticky flag, set when bytes were dropped because memory was full.
- `words_o` output AW+1: number of words loaded so far.

## Operation
- **States:**
  - LOAD: `ld_ready`=1, `cpu_rst_o`=1.
  - RUN: `ld_ready`=0, `cpu_rst_o`=0.
  - `rst` forces LOAD.
- **Handshake:** a byte transfers on any rising edge where `ld_valid` && `ld_ready`.
- **Byte assembly:**
  - Bytes are big-endian. The first byte of each word goes to [31:24], the fourth to [7:0].
  - A 2-bit byte counter and a 24-bit staging register hold the partial word.
  - On the 4th byte, the word is written to `mem[wr_ptr]`, `wr_ptr` increments, and the byte counter clears.
- **Last byte:**
  - A byte with `ld_last`=1 completes its word immediately. Any remaining lower bytes are zero-padded.
  - That word is written and the state moves to RUN.
  - If `ld_last` falls on the 4th byte, no extra word is written.
- **Overflow:**
  - When `wr_ptr`==2^AW, accepted bytes are discarded and `ovf_o` is set.
  - `ld_last` is still honoured, so the state moves to RUN.
- **LOAD → RUN:** only on an `ld_last` handshake.
- **RUN → LOAD:** on `reload`=1. This clears `wr_ptr`, the byte counter and `ovf_o`, and reasserts `cpu_rst_o`.
- **`reload` in LOAD:** restarts the load and discards the partial word.
- **`reload` together with a byte handshake:** `reload` wins and the byte is dropped.
- **Fetch:**
  - `inst` = `mem[addr[AW+1:2]]` when all of the following hold; otherwise `inst` = 32'h0 (NOP):
    - `ce`=1;
    - state is RUN;
    - `addr[31:AW+2]`==0;
    - `addr[AW+1:2]` < `wr_ptr`.
  - `addr[1:0]` is ignored.
- **`words_o`** equals `wr_ptr`, which ranges 0 to 2^AW.
- **Memory array:** not reset. Contents outside [0, `wr_ptr`) are never visible on `inst`.

## Timing
- **Reset values:**
  - state LOAD, `ld_ready`=1, `cpu_rst_o`=1;
  - `ovf_o`=0, `words_o`=0;
  - `inst`=0, since the fetch gate requires RUN.
  - Byte counter and staging register are cleared.
- **Fetch read is combinational.** `inst` is valid in the same cycle as `addr`. The core's IF/ID register captures it at the next edge, so fetch adds zero cycles.
- **Load latency:** a word write takes effect at the edge of its 4th handshake (or its `ld_last` handshake). It is readable from the following cycle.
- **`cpu_rst_o` is registered.**
  - It falls on the edge that accepts the `ld_last` byte.
  - The core's first unreset cycle is the next cycle; it fetches address 0, which is already written.
  - It rises on the edge after `reload` is sampled.
- `rst` asserted mid-load abandons the image: `words_o` is 0 the next cycle.

## Test plan
- **Basic load and run:** after reset, send 8 bytes 3C,01,12,34,34,21,56,78 with `ld_last` on the 8th.
  - `words_o`=2 and `cpu_rst_o` goes 0 one cycle after the 8th handshake.
  - `addr`=0 gives `inst`=3C011234; `addr`=4 gives 34215678; `addr`=8 gives 0.
- **Partial word:** send 5 bytes 11,22,33,44,AA with `ld_last` on the 5th.
  - `words_o`=2; `addr`=4 gives AA000000.
  - Also, `ce`=0 at `addr`=0 gives `inst`=0.
- **Backpressure and gaps:** toggle `ld_valid` randomly over 4 bytes DE,AD,BE,EF with `ld_last`.
  - Only the valid cycles count; `mem[0]`=DEADBEEF.
  - `ld_ready` stays 1 until the `ld_last` edge, then 0.
- **Overflow:** with `AW`=2, stream 20 bytes with `ld_last` on the 20th.
  - `words_o`=4, `ovf_o`=1, state is RUN.
  - `addr`=12 returns byte 13..16; `addr`=16 returns 0.
- **Reload:** in RUN, pulse `reload` on the same cycle as a driven `ld_valid`.
  - The byte is dropped; `cpu_rst_o`=1 the next cycle; `words_o`=0; all fetches return 0.
  - A new 4-byte image with `ld_last` then releases the core again.
- **Reset mid-load:** after 6 bytes, assert `rst` for 1 cycle.
  - `words_o`=0, byte counter cleared, `cpu_rst_o`=1.
  - A subsequent 4-byte load places its first byte at [31:24] of word 0.
